mp5_ts_fifo_bank: RTL and testbench

Parametrised per-stage ingress buffer for the MP5 multi-pipeline datapath. It holds one FIFO per upstream pipeline and accepts up to one push per channel per cycle. Each cycle it pops the globally oldest eligible head, ordering by a wrap-aware timestamp, and steers that packet to the output lane named in its destination field. It supports phantom reservations: a slot is booked now, its payload is filled in later, and the slot blocks its FIFO head until the fill arrives.

---
 rtl/mp5_ts_fifo_bank.sv | 157 +++++++++++++++
 tb/tb_mp5_ts_fifo_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp5_ts_fifo_bank.sv
// Per-stage ingress buffer: one FIFO per upstream pipeline, oldest-timestamp-first
// pop steered to the head's destination lane, with phantom (reserve-then-fill) slots.
module mp5_ts_fifo_bank #(
  parameter int unsigned NUM_PIPELINES = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned DATA_W        = 512,
  parameter int unsigned ID_W          = 16,
  parameter int unsigned TS_W          = 16,
  localparam int unsigned PW = $clog2(NUM_PIPELINES),
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PIPELINES-1:0]      in_valid,
  output logic [NUM_PIPELINES-1:0]      in_ready,
  input  logic [NUM_PIPELINES*DATA_W-1:0] in_data,
  input  logic [NUM_PIPELINES*PW-1:0]   in_dest,
  input  logic [NUM_PIPELINES-1:0]      in_phantom,
  input  logic [NUM_PIPELINES*ID_W-1:0] in_id,
  output logic [NUM_PIPELINES-1:0]      rsv_valid,
  output logic [NUM_PIPELINES*ID_W-1:0] rsv_id,
  output logic [NUM_PIPELINES*AW-1:0]   rsv_addr,
  input  logic                          fill_valid,
  input  logic [PW-1:0]                 fill_fifo,
  input  logic [AW-1:0]                 fill_addr,
  input  logic [DATA_W-1:0]             fill_data,
  output logic                          fill_err,
  output logic [NUM_PIPELINES-1:0]      out_valid,
  input  logic [NUM_PIPELINES-1:0]      out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [PW-1:0]                 out_fifo,
  output logic [TS_W-1:0]               out_ts
);

  localparam int unsigned NP    = NUM_PIPELINES;
  localparam int unsigned NODES = 2 * NP - 1;

  logic [AW:0]           head [NP];
  logic [AW:0]           tail [NP];
  logic [FIFO_DEPTH-1:0] pending [NP];
  logic [DATA_W-1:0]     mem_data [NP][FIFO_DEPTH];
  logic [PW-1:0]         mem_dest [NP][FIFO_DEPTH];
  logic [TS_W-1:0]       mem_ts   [NP][FIFO_DEPTH];
  logic [TS_W-1:0]       curr_time;

  logic [AW:0]      used [NP];
  logic [TS_W-1:0]  age  [NP];
  logic [NP-1:0]    full;
  logic [NP-1:0]    empty;
  logic [NP-1:0]    eligible;
  logic [NP-1:0]    push;

  logic             node_v   [NODES];
  logic [TS_W-1:0]  node_age [NODES];
  logic [PW-1:0]    node_idx [NODES];

  logic             sel_v;
  logic [PW-1:0]    sel;
  logic [AW-1:0]    sel_slot;
  logic [PW-1:0]    sel_dest;
  logic             pop;
  logic             fill_hit;

  // Per-FIFO occupancy and head eligibility
  always_comb begin
    for (int i = 0; i < int'(NP); i++) begin
      used[i]     = tail[i] - head[i];
      full[i]     = (used[i] == (AW+1)'(FIFO_DEPTH));
      empty[i]    = (head[i] == tail[i]);
      eligible[i] = !empty[i] && !pending[i][head[i][AW-1:0]];
      age[i]      = curr_time - mem_ts[i][head[i][AW-1:0]];
    end
  end

  assign in_ready  = ~full;
  assign push      = in_valid & in_ready;
  assign rsv_valid = in_valid & in_ready & in_phantom;
  assign rsv_id    = in_id;

  always_comb begin
    rsv_addr = '0;
    for (int i = 0; i < int'(NP); i++) rsv_addr[i*AW +: AW] = tail[i][AW-1:0];
  end

  // Heap-ordered compare tree; the left child always holds lower indices, so ties go left
  always_comb begin
    for (int i = 0; i < int'(NP); i++) begin
      node_v[int'(NP)-1+i]   = eligible[i];
      node_age[int'(NP)-1+i] = age[i];
      node_idx[int'(NP)-1+i] = PW'(i);
    end
    for (int n = int'(NP) - 2; n >= 0; n--) begin
      if (node_v[2*n+1] && (!node_v[2*n+2] || node_age[2*n+1] >= node_age[2*n+2])) begin
        node_v[n]   = node_v[2*n+1];
        node_age[n] = node_age[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end else begin
        node_v[n]   = node_v[2*n+2];
        node_age[n] = node_age[2*n+2];
        node_idx[n] = node_idx[2*n+2];
      end
    end
  end

  assign sel_v    = node_v[0];
  assign sel      = node_idx[0];
  assign sel_slot = head[sel][AW-1:0];
  assign sel_dest = mem_dest[sel][sel_slot];
  assign pop      = sel_v && out_ready[sel_dest];
  assign out_data = mem_data[sel][sel_slot];
  assign out_fifo = sel;
  assign out_ts   = mem_ts[sel][sel_slot];
  assign fill_hit = pending[fill_fifo][fill_addr];

  always_comb begin
    out_valid = '0;
    if (sel_v) out_valid[sel_dest] = 1'b1;
  end

  // Pointers, pending bits, timebase and fill error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NP); i++) begin
        head[i]    <= '0;
        tail[i]    <= '0;
        pending[i] <= '0;
      end
      curr_time <= '0;
      fill_err  <= 1'b0;
    end else begin
      curr_time <= curr_time + TS_W'(1);
      fill_err  <= fill_valid && !fill_hit;
      for (int i = 0; i < int'(NP); i++) begin
        if (push[i]) begin
          tail[i] <= tail[i] + (AW+1)'(1);
          pending[i][tail[i][AW-1:0]] <= in_phantom[i];
        end
        if (pop && sel == PW'(i)) head[i] <= head[i] + (AW+1)'(1);
      end
      // A hit slot is never the push tail nor the popped head, so no write collides
      if (fill_valid && fill_hit) pending[fill_fifo][fill_addr] <= 1'b0;
    end
  end

  // Slot payload storage (not reset)
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NP); i++) begin
      if (push[i]) begin
        mem_data[i][tail[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
        mem_dest[i][tail[i][AW-1:0]] <= in_dest[i*PW +: PW];
        mem_ts[i][tail[i][AW-1:0]]   <= curr_time;
      end
    end
    if (fill_valid && fill_hit) mem_data[fill_fifo][fill_addr] <= fill_data;
  end

endmodule

// File: tb/tb_mp5_ts_fifo_bank.sv
// Scoreboard bench for mp5_ts_fifo_bank: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops the predictions and compares.
module tb_mp5_ts_fifo_bank;
  localparam int unsigned NP = 8, DEPTH = 8, DW = 32, IDW = 16, TSW = 4, PW = 3, AW = 3;
  localparam int TSMOD = 1 << TSW;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       in_valid, in_ready, in_phantom, rsv_valid, out_valid, out_ready;
  logic [NP*DW-1:0]    in_data;
  logic [NP*PW-1:0]    in_dest;
  logic [NP*IDW-1:0]   in_id, rsv_id;
  logic [NP*AW-1:0]    rsv_addr;
  logic                fill_valid, fill_err;
  logic [PW-1:0]       fill_fifo, out_fifo;
  logic [AW-1:0]       fill_addr;
  logic [DW-1:0]       fill_data, out_data;
  logic [TSW-1:0]      out_ts;

  mp5_ts_fifo_bank #(.NUM_PIPELINES(NP), .FIFO_DEPTH(DEPTH), .DATA_W(DW), .ID_W(IDW), .TS_W(TSW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_phantom(in_phantom), .in_id(in_id), .rsv_valid(rsv_valid),
    .rsv_id(rsv_id), .rsv_addr(rsv_addr), .fill_valid(fill_valid), .fill_fifo(fill_fifo),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_err(fill_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_fifo(out_fifo), .out_ts(out_ts));

  always #5 clk = ~clk;

  typedef struct { int ch; logic [DW-1:0] data; int dest; int ts; bit pend; int addr; } ent_t;
  typedef struct {
    logic [NP-1:0] rdy; logic [NP-1:0] ov; logic [DW-1:0] data; int fifo; int ts;
    logic [NP-1:0] rv; logic [NP*AW-1:0] raddr; logic [NP*IDW-1:0] id; logic ferr;
  } exp_t;

  ent_t mq[$];     // every resident entry, in arrival order across all channels
  exp_t exp_q[$];
  exp_t mon_e;
  int   waddr[NP];
  int   mtime;
  bit   mferr;
  bit   chk_en;
  int   checks = 0, errors = 0;

  function automatic int head_pos(int ch);
    for (int k = 0; k < mq.size(); k++) if (mq[k].ch == ch) return k;
    return -1;
  endfunction

  function automatic int count(int ch);
    int c = 0;
    foreach (mq[k]) if (mq[k].ch == ch) c++;
    return c;
  endfunction

  // Oldest unblocked head by wrap-aware age; strict '>' keeps the lowest channel on ties
  function automatic int pick();
    int best = -1, bage = -1, p, a;
    for (int ch = 0; ch < int'(NP); ch++) begin
      p = head_pos(ch);
      if (p >= 0 && !mq[p].pend) begin
        a = ((mtime - mq[p].ts) % TSMOD + TSMOD) % TSMOD;
        if (a > bage) begin bage = a; best = p; end
      end
    end
    return best;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("in_ready",  128'(in_ready),  128'(mon_e.rdy));
      chk("out_valid", 128'(out_valid), 128'(mon_e.ov));
      chk("rsv_valid", 128'(rsv_valid), 128'(mon_e.rv));
      chk("rsv_addr",  128'(rsv_addr),  128'(mon_e.raddr));
      chk("rsv_id",    128'(rsv_id),    128'(mon_e.id));
      chk("fill_err",  128'(fill_err),  128'(mon_e.ferr));
      if (mon_e.ov != '0) begin
        chk("out_data", 128'(out_data), 128'(mon_e.data));
        chk("out_fifo", 128'(out_fifo), 128'(mon_e.fifo));
        chk("out_ts",   128'(out_ts),   128'(mon_e.ts));
      end
    end
  end

  // Predict this cycle's outputs, then advance the model across the coming edge
  task automatic cycle();
    exp_t e;
    ent_t n;
    int   s;
    bit   found;
    s = pick();
    e.ov = '0; e.data = '0; e.fifo = 0; e.ts = 0;
    for (int ch = 0; ch < int'(NP); ch++) begin
      e.rdy[ch] = (count(ch) < int'(DEPTH));
      e.raddr[ch*AW +: AW] = AW'(waddr[ch]);
    end
    if (s >= 0) begin
      e.ov[mq[s].dest] = 1'b1;
      e.data = mq[s].data; e.fifo = mq[s].ch; e.ts = mq[s].ts;
    end
    e.rv = in_valid & e.rdy & in_phantom;
    e.id = in_id;
    e.ferr = mferr;
    if (chk_en) exp_q.push_back(e);
    if (rst) begin
      mq.delete();
      foreach (waddr[ch]) waddr[ch] = 0;
      mtime = 0;
      mferr = 1'b0;
    end else begin
      found = 1'b0;
      if (fill_valid) begin
        foreach (mq[k])
          if (mq[k].ch == int'(fill_fifo) && mq[k].addr == int'(fill_addr) && mq[k].pend) begin
            mq[k].data = fill_data; mq[k].pend = 1'b0; found = 1'b1;
          end
      end
      mferr = fill_valid && !found;
      if (s >= 0 && out_ready[mq[s].dest]) mq.delete(s);
      for (int ch = 0; ch < int'(NP); ch++) begin
        if (in_valid[ch] && e.rdy[ch]) begin
          n.ch = ch; n.data = in_data[ch*DW +: DW]; n.dest = int'(in_dest[ch*PW +: PW]);
          n.ts = mtime; n.pend = in_phantom[ch]; n.addr = waddr[ch];
          mq.push_back(n);
          waddr[ch] = (waddr[ch] + 1) % int'(DEPTH);
        end
      end
      mtime = (mtime + 1) % TSMOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = '0; in_phantom = '0; in_data = '0; in_dest = '0; in_id = '0;
    fill_valid = 1'b0; fill_fifo = '0; fill_addr = '0; fill_data = '0;
  endtask

  task automatic put(int ch, logic [DW-1:0] d, int dest, bit ph, logic [IDW-1:0] id);
    in_valid[ch] = 1'b1; in_phantom[ch] = ph;
    in_data[ch*DW +: DW] = d; in_dest[ch*PW +: PW] = PW'(dest); in_id[ch*IDW +: IDW] = id;
  endtask

  task automatic fill(int f, int a, logic [DW-1:0] d);
    fill_valid = 1'b1; fill_fifo = PW'(f); fill_addr = AW'(a); fill_data = d;
  endtask

  task automatic idle(int n);
    clr();
    repeat (n) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int oaddr;
    int pl[$];
    clr();
    out_ready = '0; rst = 1'b1; chk_en = 1'b0; mtime = 0; mferr = 1'b0;
    foreach (waddr[ch]) waddr[ch] = 0;
    @(posedge clk); #1;
    repeat (2) cycle();
    rst = 1'b0; chk_en = 1'b1;

    // Ordering: A on ch2, then B on ch5 and C on ch0 together
    out_ready = '1;
    clr(); put(2, 32'hA, 4, 0, 16'h0); cycle();
    clr(); put(5, 32'hB, 1, 0, 16'h0); put(0, 32'hC, 6, 0, 16'h0); cycle();
    idle(4);

    // Full and backpressure on ch3
    out_ready = '0;
    for (int k = 0; k < 8; k++) begin clr(); put(3, 32'h300 + 32'(k), k % 8, 0, 16'h0); cycle(); end
    clr(); put(3, 32'hDEAD, 2, 0, 16'h0); cycle();
    idle(2);
    out_ready = '1;
    idle(10);

    // Phantom reservation blocks ch1 until filled
    clr(); put(1, 32'h0, 2, 1, 16'h1234); put(4, 32'h44, 5, 0, 16'h0); cycle();
    clr(); put(1, 32'h55, 3, 0, 16'h0); put(6, 32'h66, 7, 0, 16'h0); cycle();
    idle(2);
    clr(); fill(1, 0, 32'hAB); cycle();
    idle(3);

    // Fills to slots that are not pending
    clr(); fill(3, 2, 32'hBAD); cycle();
    idle(1);
    clr(); fill(1, 0, 32'hBAD2); cycle();
    idle(2);

    // Timestamp wrap: ch0 at time 14, ch1 at time 1
    out_ready = '0;
    for (int k = 0; k < 20 && mtime != 14; k++) idle(1);
    clr(); put(0, 32'hE0, 3, 0, 16'h0); cycle();
    for (int k = 0; k < 20 && mtime != 1; k++) idle(1);
    clr(); put(1, 32'hE1, 3, 0, 16'h0); cycle();
    out_ready = '1;
    idle(4);

    // Reset with three reservations and five valid entries resident
    out_ready = '0;
    oaddr = waddr[0];
    clr();
    for (int ch = 0; ch < 3; ch++) put(ch, 32'h0, ch, 1, 16'(16'h100 + ch));
    for (int ch = 3; ch < 8; ch++) put(ch, 32'h900 + 32'(ch), ch, 0, 16'h0);
    cycle();
    idle(1);
    clr(); rst = 1'b1; cycle(); rst = 1'b0;
    idle(1);
    clr(); fill(0, oaddr, 32'h77); cycle();
    idle(2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clr();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; cycle(); rst = 1'b0;
        continue;
      end
      in_valid   = NP'($urandom) & NP'($urandom);
      in_phantom = NP'($urandom) & NP'($urandom);
      for (int ch = 0; ch < int'(NP); ch++) begin
        in_data[ch*DW +: DW]  = DW'($urandom);
        in_dest[ch*PW +: PW]  = PW'($urandom);
        in_id[ch*IDW +: IDW]  = IDW'($urandom);
      end
      out_ready = NP'($urandom) | NP'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        pl.delete();
        foreach (mq[k]) if (mq[k].pend) pl.push_back(k);
        if (pl.size() > 0 && $urandom_range(0, 3) != 0) begin
          int k;
          k = pl[$urandom_range(0, pl.size() - 1)];
          fill(mq[k].ch, mq[k].addr, DW'($urandom));
        end else begin
          fill(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        end
      end
      cycle();
    end
    out_ready = '1;
    idle(4);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
